// File: rtl/gpu_pkg.sv
// Shared geometry, fill character, FSM states and pending-request encoding
// for the character-buffer fill engine.
package gpu_pkg;
  localparam int ROWS    = 30;
  localparam int COLS_80 = 80;
  localparam int COLS_40 = 40;
  localparam int ADDR_W  = 12;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic [1:0] {IDLE, FILL_SCREEN, FILL_LINE, FINISH} fill_state_e;
  typedef enum logic {REQ_LINE = 1'b0, REQ_CLEAR = 1'b1} req_e;

  typedef struct packed {
    logic       vld;
    req_e       kind;
    logic [4:0] sel;
    logic       mode80;
  } slot_t;

  // Line stride is 80 = 64+16 or 40 = 32+8, so the base needs no multiplier.
  function automatic logic [ADDR_W-1:0] line_base(input logic [4:0] sel, input logic mode80);
    logic [ADDR_W-1:0] s;
    s = {{(ADDR_W-5){1'b0}}, sel};
    return mode80 ? (s << 6) + (s << 4) : (s << 5) + (s << 3);
  endfunction
endpackage

// File: rtl/fill_addr_gen.sv
// Fill address counter: latches base and end on load, steps once per advance,
// flags the last address combinationally from registered state.
module fill_addr_gen
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              line_i,
  input  logic              mode80_i,
  input  logic [4:0]        sel_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] cnt_q, cnt_d, end_q, end_d;
  logic [ADDR_W-1:0] base, len;

  always_comb begin
    base  = line_i ? line_base(sel_i, mode80_i) : '0;
    if (line_i) len = mode80_i ? ADDR_W'(COLS_80) : ADDR_W'(COLS_40);
    else        len = mode80_i ? ADDR_W'(ROWS * COLS_80) : ADDR_W'(ROWS * COLS_40);
    cnt_d = cnt_q;
    end_d = end_q;
    if (load_i) begin
      cnt_d = base;
      end_d = base + len - ADDR_W'(1);
    end else if (adv_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      end_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      end_q <= end_d;
    end
  end

  assign addr_o = cnt_q;
  assign last_o = (cnt_q == end_q);
endmodule

// File: rtl/text_fill_engine.sv
// Character-buffer write arbiter: CPU writes pass with priority, clear/line fills use idle cycles.
// One-cycle registered write path; one pending request is held while busy, extras set overflow.
module text_fill_engine
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_data,
  input  logic              cpu_we,
  input  logic              mode_80col,
  input  logic              clear_req,
  input  logic              line_req,
  input  logic [4:0]        line_sel,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              buf_we,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  fill_state_e       state_q, state_d;
  slot_t             slot_q, slot_d;
  logic              ovf_q, ovf_d;
  logic              done_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [7:0]        buf_data_q;
  logic              buf_we_q;

  logic              load, load_line, load_mode, take_new, fill_we;
  logic              line_ok, line_bad, fill_last;
  req_e              load_kind;
  logic [4:0]        load_sel;
  logic [ADDR_W-1:0] fill_addr;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    load_kind = REQ_CLEAR;
    load_sel  = line_sel;
    load_mode = mode_80col;
    take_new  = 1'b0;
    fill_we   = 1'b0;
    line_bad  = line_req && !clear_req && (line_sel >= 5'(ROWS));
    line_ok   = line_req && !clear_req && (line_sel < 5'(ROWS));
    if (line_bad) ovf_d = 1'b1;

    case (state_q)
      IDLE, FINISH: begin
        if (state_q == FINISH) state_d = IDLE;
        if (slot_q.vld) begin
          load       = 1'b1;
          load_kind  = slot_q.kind;
          load_sel   = slot_q.sel;
          load_mode  = slot_q.mode80;
          slot_d.vld = 1'b0;
        end else if (state_q == IDLE && (clear_req || line_ok)) begin
          load      = 1'b1;
          load_kind = clear_req ? REQ_CLEAR : REQ_LINE;
          take_new  = 1'b1;
        end
        if (load) state_d = (load_kind == REQ_CLEAR) ? FILL_SCREEN : FILL_LINE;
      end
      FILL_SCREEN, FILL_LINE: begin
        if (!cpu_we) begin
          fill_we = 1'b1;
          if (fill_last) state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Requests not started directly go to the slot; a clear supersedes a pending line.
    if (!take_new) begin
      if (clear_req) begin
        if (!slot_d.vld || slot_d.kind == REQ_LINE)
          slot_d = '{vld: 1'b1, kind: REQ_CLEAR, sel: line_sel, mode80: mode_80col};
      end else if (line_ok) begin
        if (!slot_d.vld) slot_d = '{vld: 1'b1, kind: REQ_LINE, sel: line_sel, mode80: mode_80col};
        else             ovf_d  = 1'b1;
      end
    end
  end

  assign load_line = (load_kind == REQ_LINE);

  fill_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .line_i   (load_line),
    .mode80_i (load_mode),
    .sel_i    (load_sel),
    .adv_i    (fill_we),
    .addr_o   (fill_addr),
    .last_o   (fill_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      buf_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ovf_q   <= ovf_d;
      done_q  <= (state_d == FINISH);
      if (cpu_we) begin
        buf_addr_q <= cpu_wr_addr;
        buf_data_q <= cpu_wr_data;
        buf_we_q   <= 1'b1;
      end else if (fill_we) begin
        buf_addr_q <= fill_addr;
        buf_data_q <= FILL_CHAR;
        buf_we_q   <= 1'b1;
      end else begin
        buf_we_q   <= 1'b0;
      end
    end
  end

  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;
  assign buf_we   = buf_we_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || slot_q.vld;
endmodule

// File: tb/tb_text_fill_engine.sv
// Scoreboard bench for text_fill_engine: stimulus queues expected writes,
// a negedge monitor pops and compares every buf_we cycle.
module tb_text_fill_engine;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_we = 1'b0;
  logic        mode_80col = 1'b0;
  logic        clear_req = 1'b0;
  logic        line_req = 1'b0;
  logic [4:0]  line_sel = '0;
  logic [11:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we, busy, done, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct { int c; logic [11:0] a; logic [7:0] d; } cpu_exp_t;
  logic [19:0] fill_q[$];
  cpu_exp_t    cpu_q[$];

  text_fill_engine dut (
    .clk(clk), .rst(rst), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_we(cpu_we), .mode_80col(mode_80col), .clear_req(clear_req), .line_req(line_req),
    .line_sel(line_sel), .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: CPU writes are checked at their exact cycle, fill writes in order.
  always @(negedge clk) begin
    logic [19:0] e;
    if (done === 1'b1) done_cnt++;
    if (cpu_q.size() != 0 && cpu_q[0].c == cyc) begin
      chk("cpu_we", 32'(buf_we), 32'd1);
      chk("cpu_addr", 32'(buf_addr), 32'(cpu_q[0].a));
      chk("cpu_data", 32'(buf_data), 32'(cpu_q[0].d));
      void'(cpu_q.pop_front());
    end else if (buf_we === 1'b1) begin
      checks++;
      if (fill_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", buf_addr, buf_data);
      end else begin
        e = fill_q.pop_front();
        if (buf_addr !== e[19:8] || buf_data !== e[7:0]) begin
          errors++;
          $display("FAIL fill_write: addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   buf_addr, buf_data, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_fill(input int base, input int n);
    for (int i = 0; i < n; i++) fill_q.push_back({12'(base + i), 8'h20});
  endtask

  task automatic req(input logic clr, input logic ln, input logic [4:0] sel, output int c0);
    clear_req = clr;
    line_req  = ln;
    line_sel  = sel;
    c0 = cyc;
    @(negedge clk);
    clear_req = 1'b0;
    line_req  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  task automatic run_check(input string name, input int c0, input int lat, input int budget);
    int at;
    wait_done(budget, at);
    chk({name, "_latency"}, 32'(at - c0 + 1), 32'(lat));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
    tick(1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_writes_left"}, 32'(fill_q.size()), 32'd0);
  endtask

  task automatic cpu_write_at(input int c, input logic [11:0] a, input logic [7:0] d);
    while (cyc < c) @(negedge clk);
    cpu_we = 1'b1;
    cpu_wr_addr = a;
    cpu_wr_data = d;
    cpu_q.push_back('{c: cyc + 1, a: a, d: d});
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  initial begin
    int c0, c1, at1, at2, dc;
    tick(2);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_buf_data", 32'(buf_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(2);

    // 40-col full clear
    mode_80col = 1'b0;
    dc = done_cnt;
    push_fill(0, 1200);
    req(1'b1, 1'b0, 5'd0, c0);
    run_check("clear40", c0, 1202, 1400);
    chk("clear40_done_count", 32'(done_cnt - dc), 32'd1);

    // 80-col bottom line
    mode_80col = 1'b1;
    push_fill(2320, 80);
    req(1'b0, 1'b1, 5'd29, c0);
    run_check("line29_80", c0, 82, 200);

    // 80-col line with three CPU writes stalling the fill
    push_fill(80, 80);
    req(1'b0, 1'b1, 5'd1, c0);
    cpu_write_at(c0 + 10, 12'd5, 8'h41);
    cpu_write_at(c0 + 30, 12'd5, 8'h41);
    cpu_write_at(c0 + 50, 12'd5, 8'h41);
    run_check("line1_cpu", c0, 85, 200);
    chk("line1_cpu_left", 32'(cpu_q.size()), 32'd0);

    // Simultaneous clear and line: clear only
    mode_80col = 1'b0;
    dc = done_cnt;
    push_fill(0, 1200);
    req(1'b1, 1'b1, 5'd7, c0);
    run_check("clear_and_line", c0, 1202, 1400);
    chk("clear_and_line_ovf", 32'(overflow), 32'd0);
    chk("clear_and_line_done_count", 32'(done_cnt - dc), 32'd1);

    // Pending slot: line3 superseded by clear, line4 dropped
    dc = done_cnt;
    push_fill(0, 40);
    req(1'b0, 1'b1, 5'd0, c0);
    tick(3);
    req(1'b0, 1'b1, 5'd3, c1);
    tick(2);
    push_fill(0, 1200);
    req(1'b1, 1'b0, 5'd0, c1);
    tick(2);
    req(1'b0, 1'b1, 5'd4, c1);
    tick(1);
    chk("pend_overflow", 32'(overflow), 32'd1);
    wait_done(100, at1);
    chk("pend_first_latency", 32'(at1 - c0 + 1), 32'd42);
    chk("pend_busy_between", 32'(busy), 32'd1);
    tick(1);
    wait_done(1400, at2);
    chk("pend_clear_latency", 32'(at2 - at1), 32'd1201);
    tick(1);
    chk("pend_busy_after", 32'(busy), 32'd0);
    chk("pend_writes_left", 32'(fill_q.size()), 32'd0);
    chk("pend_done_count", 32'(done_cnt - dc), 32'd2);

    rst = 1'b1;
    tick(2);
    chk("rst2_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(1);

    // Out-of-range line: ignored, overflow set
    dc = done_cnt;
    req(1'b0, 1'b1, 5'd30, c0);
    tick(1);
    chk("bad_line_busy", 32'(busy), 32'd0);
    tick(4);
    chk("bad_line_overflow", 32'(overflow), 32'd1);
    chk("bad_line_done_count", 32'(done_cnt - dc), 32'd0);

    // Reset mid-clear
    push_fill(0, 1200);
    req(1'b1, 1'b0, 5'd0, c0);
    tick(100);
    chk("midclear_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_buf_we", 32'(buf_we), 32'd0);
    chk("arst_buf_addr", 32'(buf_addr), 32'd0);
    chk("arst_buf_data", 32'(buf_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    fill_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    chk("post_reset_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_fill_engine.md
Name: text_fill_engine

Overview:
Hardware clear/scroll-fill engine and write-port arbiter for the character buffer write port, in the clk_cpu domain between gpu_registers and character_buffer. It multiplexes single CPU character writes with burst fills of FILL_CHAR. A full-screen fill handles clear; a single physical-line fill handles the new bottom line after a circular-buffer scroll (top_line advance). This removes the CPU loops for clear (1200/2400 writes) and scroll-line clear (40/80 writes).

Parameters:
ROWS, 30, text rows per screen
COLS_80, 80, columns (and line stride) in 80-col mode
COLS_40, 40, columns (and line stride) in 40-col mode
FILL_CHAR, 8'h20, character code written by fills
ADDR_W, 12, character buffer address width

Ports:
clk  in  1  system clock (clk_cpu domain)
rst  in  1  asynchronous reset, active-high
cpu_wr_addr  in  ADDR_W  CPU write address from gpu_registers
cpu_wr_data  in  8  CPU write data
cpu_we  in  1  CPU write strobe, one cycle per write
mode_80col  in  1  1 = 80-col geometry, 0 = 40-col
clear_req  in  1  one-cycle pulse: fill the whole screen
line_req  in  1  one-cycle pulse: fill one physical line
line_sel  in  5  physical line for line_req (0..ROWS-1)
buf_addr  out  ADDR_W  to character_buffer addr_write
buf_data  out  8  to character_buffer data_write
buf_we  out  1  to character_buffer we
busy  out  1  high while a fill is active or pending
done  out  1  one-cycle pulse after the last fill write of an operation
overflow  out  1  sticky: a request was lost because the pending slot was full

Behaviour:
- Reset (async, rst=1): state IDLE, buf_addr=0, buf_data=0, buf_we=0, busy=0, done=0, overflow=0, pending slot empty.
- Outputs are registered: a CPU write or fill write appears on buf_* one cycle after it is issued.
- Arbitration: cpu_we has absolute priority. When cpu_we=1, the CPU write passes through and the fill counter stalls for that cycle, with no fill write issued. CPU writes are never dropped or delayed more than one cycle.
- A CPU write to a not-yet-filled address during a fill is later overwritten. Software polls busy before writing content after clear.
- Geometry: cols = mode_80col ? COLS_80 : COLS_40. mode_80col is latched at operation start and is constant for the whole operation.
- Line base address = line_sel*cols, computed by shift-add: 80 = 64+16, 40 = 32+8. No multiplier.
- States:
  - IDLE: a request, or the pending slot, starts an operation. If both clear_req and line_req occur, clear wins and line_req is discarded, since clear covers it.
  - FILL_SCREEN: addr runs 0 .. ROWS*cols-1, one write per non-stalled cycle.
  - FILL_LINE: addr runs base .. base+cols-1.
  - FINISH: done=1 for one cycle, then go to IDLE, or straight into the pending operation.
- Request while busy is held in a 1-entry pending slot (type + line_sel + mode sampled at start):
  - clear_req while busy: if the slot is empty or holds a line request, the slot becomes clear. A pending line is superseded and overflow is not set.
  - line_req while busy with the slot empty: stored in the slot.
  - line_req while busy with the slot holding line or clear: the request is dropped and overflow=1.
- line_sel >= ROWS is ignored: no writes, no done pulse, overflow=1.
- overflow clears only on reset.
- busy = (state != IDLE) or slot valid. busy rises the cycle after the accepted request and falls the cycle after done.
- Fill latency: full screen takes ROWS*cols + 2 cycles with no CPU contention (1202 in 40-col, 2402 in 80-col). A line takes cols + 2 cycles.
- Reset mid-fill aborts immediately; the buffer contents are left partially filled.

Decomposition:
- Package gpu_pkg: ROWS/COLS constants, FILL_CHAR, fill state enum (IDLE, FILL_SCREEN, FILL_LINE, FINISH), request-type encoding.
- Sub-module fill_addr_gen: latched base + length, counter, stall input, last-flag output, shift-add base computation. The parent holds the FSM, arbiter mux and pending slot.

Test Plan:
- 40-col, clear_req, no CPU traffic -> buf_we high for exactly 1200 consecutive cycles, addr 0..1199, data 0x20; done pulses once; busy drops one cycle later.
- 80-col, line_req with line_sel=29 -> 80 writes at addr 2320..2399, data 0x20; done pulses once.
- During an 80-col line fill, cpu_we with addr 5, data 0x41 for 3 separated cycles -> 0x41 written at 5 each time, one cycle later. Fill stalls 3 cycles, still completes all 80 addresses, total 85 cycles.
- While busy, line_req(3) then clear_req then line_req(4) -> line 3 superseded; clear runs after the current operation; line 4 is dropped with overflow=1; done pulses twice in total.
- line_sel=30 in IDLE -> no writes, overflow=1. Then assert rst mid-clear -> all outputs 0 asynchronously and overflow cleared.
- Simultaneous clear_req and line_req in IDLE -> only the full clear executes; overflow stays 0.
